// File: rtl/comparator_sweep_pkg.sv
// rtl/comparator_sweep_pkg.sv - shared FSM encodings and default width for the comparator sweep
// Purpose: state encoding and default operand width used by comparator_sweep.
// Contents: state_t (ST_IDLE, ST_RUN, ST_DONE), COMP_WIDTH.
package comparator_sweep_pkg;

  localparam int COMP_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/comparator_sweep_counter.sv
// rtl/comparator_sweep_counter.sv - sweep_counter: clearable, enabled up-counter with terminal flag
// Purpose: walks every operand pair; the top splits value into {a_out, b_out}.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clear      load zero (priority over en)
//   en         advance by one, wrapping all-ones -> zero
//   value      current count (N bits)
//   tc         high while value is all ones
module sweep_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [N-1:0] value,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= '0;
    end else if (en) begin
      value <= value + N'(1);
    end
  end

  assign tc = &value;

endmodule

// File: rtl/comparator_sweep.sv
// rtl/comparator_sweep.sv - exhaustive driver/checker for a WIDTH-bit equality comparator
// Purpose: on start, presents every (A,B) pair one per cycle, checks the returned
//   equality bit against A==B, and reports match/error counts and pass.
// Optional feature macro: ERR_CAPTURE_EN adds first_err_a/first_err_b/first_err_valid.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         sweep request, honoured in IDLE or DONE only
//   a_out, b_out  operand pair driven to the comparator
//   e_in          comparator equality result (combinational from a_out/b_out)
//   busy          sweep in progress
//   done          sweep finished, held until next start or rst
//   match_count   pairs with A==B seen this sweep
//   error_count   pairs where e_in disagreed with A==B
//   pass          done and no errors
//   first_err_*   (ERR_CAPTURE_EN) pair of the first error in the sweep
module comparator_sweep
  import comparator_sweep_pkg::*;
#(
  parameter int WIDTH = COMP_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               e_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH:0]     match_count,
  output logic [2*WIDTH:0]   error_count,
  output logic               pass
`ifdef ERR_CAPTURE_EN
  ,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b,
  output logic               first_err_valid
`endif
);

  state_t state, state_nxt;
  logic   cnt_clear, cnt_en, cnt_tc;
  logic   expected, mismatch;

  sweep_counter #(.N(2*WIDTH)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .value ({a_out, b_out}),
    .tc    (cnt_tc)
  );

  assign expected = (a_out == b_out);
  assign mismatch = (e_in != expected);

  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_RUN;
          cnt_clear = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        // The last pair is checked on this same edge; the counter wraps to zero.
        if (cnt_tc) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
    end
  end

  // Scoreboard counters: cleared on sweep entry, accumulate only while running.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      match_count <= '0;
      error_count <= '0;
    end else if (state == ST_RUN) begin
      match_count <= match_count + (WIDTH+1)'(expected);
      error_count <= error_count + (2*WIDTH+1)'(mismatch);
    end
  end

  assign pass = done && (error_count == '0);

`ifdef ERR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_valid <= 1'b0;
    end else if (state == ST_RUN && mismatch && !first_err_valid) begin
      first_err_a     <= a_out;
      first_err_b     <= b_out;
      first_err_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_comparator_sweep.sv
// tb/tb_comparator_sweep.sv - scoreboard bench for comparator_sweep with a fault-map comparator model
module tb_comparator_sweep;

  localparam int W      = 4;
  localparam int NV     = 2 ** W;
  localparam int NPAIRS = 2 ** (2 * W);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     a_out, b_out;
  logic             e_in;
  logic             busy, done, pass;
  logic [W:0]       match_count;
  logic [2*W:0]     error_count;
`ifdef ERR_CAPTURE_EN
  logic [W-1:0]     first_err_a, first_err_b;
  logic             first_err_valid;
`endif

  // Comparator under test: a correct comparator with selected pairs inverted.
  logic [NPAIRS-1:0] fault_map = '0;

  always #5 clk = ~clk;

  assign e_in = (a_out == b_out) ^ fault_map[{a_out, b_out}];

  comparator_sweep #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a_out       (a_out),
    .b_out       (b_out),
    .e_in        (e_in),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .error_count (error_count),
    .pass        (pass)
`ifdef ERR_CAPTURE_EN
    ,
    .first_err_a     (first_err_a),
    .first_err_b     (first_err_b),
    .first_err_valid (first_err_valid)
`endif
  );

  typedef struct {
    int m;
    int e;
    int p;
    int fa;
    int fb;
    int fv;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: walk all pairs in sweep order and apply the counting rules directly.
  function automatic exp_t model(input logic [NPAIRS-1:0] map);
    exp_t r;
    r = '{m: 0, e: 0, p: 0, fa: 0, fb: 0, fv: 0};
    for (int a = 0; a < NV; a++) begin
      for (int b = 0; b < NV; b++) begin
        if (a == b) r.m++;
        if (map[a * NV + b]) begin
          r.e++;
          if (r.fv == 0) begin
            r.fv = 1;
            r.fa = a;
            r.fb = b;
          end
        end
      end
    end
    r.p = (r.e == 0) ? 1 : 0;
    return r;
  endfunction

  // Monitor: measures busy length, checks clearing on sweep entry, pops on done.
  int   busy_cycles = 0;
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      busy_cycles = 0;
      busy_prev   = 1'b0;
      done_prev   = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        chk("entry_match_cleared", int'(match_count), 0);
        chk("entry_error_cleared", int'(error_count), 0);
      end
      if (busy) busy_cycles++;
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("busy_cycles", busy_cycles, NPAIRS);
          chk("match_count", int'(match_count), x.m);
          chk("error_count", int'(error_count), x.e);
          chk("pass", int'(pass), x.p);
          chk("busy_at_done", int'(busy), 0);
          chk("ab_wrapped", int'({a_out, b_out}), 0);
`ifdef ERR_CAPTURE_EN
          chk("first_err_valid", int'(first_err_valid), x.fv);
          chk("first_err_a", int'(first_err_a), x.fa);
          chk("first_err_b", int'(first_err_b), x.fb);
`endif
        end
        busy_cycles = 0;
      end
      busy_prev = busy;
      done_prev = done;
    end
  end

  task automatic check_idle_zero(input string tag);
    chk({tag, "_a"}, int'(a_out), 0);
    chk({tag, "_b"}, int'(b_out), 0);
    chk({tag, "_match"}, int'(match_count), 0);
    chk({tag, "_error"}, int'(error_count), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3 * NPAIRS; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic sweep(input logic [NPAIRS-1:0] map);
    fault_map = map;
    exp_q.push_back(model(map));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
  endtask

  logic [NPAIRS-1:0] m;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");

    // Correct comparator.
    sweep('0);

    // e_in tied high: every unequal pair is a fault.
    for (int i = 0; i < NPAIRS; i++) m[i] = ((i / NV) != (i % NV));
    sweep(m);

    // Inverted comparator.
    sweep('1);

    // Sparse random faults.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NPAIRS; i++) m[i] = ($urandom_range(0, 15) == 0);
      sweep(m);
    end

    // Abort at RUN cycle 100, then a clean sweep.
    fault_map = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 100 && busy; i++) @(negedge clk);
    chk("abort_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("abort");
    rst = 1'b0;
    sweep('0);

    // Start held through RUN, then seen in DONE: exactly two back-to-back sweeps.
    fault_map = '0;
    fault_map[NV + 2] = 1'b1;
    exp_q.push_back(model(fault_map));
    exp_q.push_back(model(fault_map));
    @(negedge clk);
    start = 1'b1;
    wait_done();
    @(negedge clk);
    start = 1'b0;
    chk("restart_from_done_busy", int'(busy), 1);
    chk("restart_done_low", int'(done), 0);
    wait_done();
    repeat (2) @(negedge clk);

    // Two faults; the first in sweep order must be the one captured.
    m = '0;
    m[9 * NV + 1] = 1'b1;
    m[3 * NV + 5] = 1'b1;
    sweep(m);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
